// File: rtl/dump_sequencer.sv
// Channel dump sequencer: fetches the channel's offset/gain calibration from the EEPROM over SPI,
// then streams all capture-RAM samples, oldest first, as corrected bytes to the UART.
module dump_sequencer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump,
  input  logic [1:0]    dump_ch,
  input  logic [2:0]    ch1_AFEgain,
  input  logic [2:0]    ch2_AFEgain,
  input  logic [2:0]    ch3_AFEgain,
  input  logic [AW-1:0] trig_addr,
  input  logic          SPI_done,
  input  logic [7:0]    corrected,
  input  logic          tx_done,
  output logic          wrt_SPI,
  output logic [2:0]    ss,
  output logic [15:0]   SPI_data,
  output logic          flopOffset,
  output logic          flopGain,
  output logic          ren,
  output logic [AW-1:0] ram_addr,
  output logic [1:0]    ch_sel,
  output logic [7:0]    tx_data,
  output logic          trmt,
  output logic          busy,
  output logic          dump_done
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] OFF_CMD  = 4'd1;
  localparam logic [3:0] OFF_WT1  = 4'd2;
  localparam logic [3:0] OFF_WT2  = 4'd3;
  localparam logic [3:0] GAIN_CMD = 4'd4;
  localparam logic [3:0] GAIN_WT1 = 4'd5;
  localparam logic [3:0] GAIN_WT2 = 4'd6;
  localparam logic [3:0] RD       = 4'd7;
  localparam logic [3:0] LAT      = 4'd8;
  localparam logic [3:0] TXW      = 4'd9;
  localparam logic [3:0] DONE     = 4'd10;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [3:0]    state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [2:0]    gain_q, gain_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   spi_data_q, spi_data_d;
  logic          wrt_q, wrt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          trmt_q, trmt_d;
  logic [2:0]    gain_sel;

  always_comb begin
    case (dump_ch)
      2'b00:   gain_sel = ch1_AFEgain;
      2'b01:   gain_sel = ch2_AFEgain;
      default: gain_sel = ch3_AFEgain;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    gain_d     = gain_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    spi_data_d = spi_data_q;
    wrt_d      = 1'b0;
    tx_data_d  = tx_data_q;
    trmt_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump && dump_ch != 2'b11) begin
          ch_d    = dump_ch;
          gain_d  = gain_sel;
          addr_d  = trig_addr;
          cnt_d   = '0;
          state_d = OFF_CMD;
        end
      end
      OFF_CMD: begin
        wrt_d      = 1'b1;
        spi_data_d = {2'b00, ch_q, gain_q, 1'b0, 8'h00};
        state_d    = OFF_WT1;
      end
      OFF_WT1: begin
        // Second transaction clocks the EEPROM read data back out.
        if (SPI_done) begin
          wrt_d      = 1'b1;
          spi_data_d = 16'h0000;
          state_d    = OFF_WT2;
        end
      end
      OFF_WT2:  if (SPI_done) state_d = GAIN_CMD;
      GAIN_CMD: begin
        wrt_d      = 1'b1;
        spi_data_d = {2'b00, ch_q, gain_q, 1'b1, 8'h00};
        state_d    = GAIN_WT1;
      end
      GAIN_WT1: begin
        if (SPI_done) begin
          wrt_d      = 1'b1;
          spi_data_d = 16'h0000;
          state_d    = GAIN_WT2;
        end
      end
      GAIN_WT2: if (SPI_done) state_d = RD;
      RD:       state_d = LAT;
      LAT: begin
        tx_data_d = corrected;
        trmt_d    = 1'b1;
        state_d   = TXW;
      end
      TXW: begin
        if (tx_done) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = (addr_q >= LAST) ? '0 : addr_q + 1'b1;
            state_d = RD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= 2'b00;
      gain_q     <= 3'b000;
      cnt_q      <= '0;
      addr_q     <= '0;
      spi_data_q <= 16'h0000;
      wrt_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      trmt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      gain_q     <= gain_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      spi_data_q <= spi_data_d;
      wrt_q      <= wrt_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= trmt_d;
    end
  end

  // Strobes line up with SPI_done so EEP_data is captured while still valid.
  assign flopOffset = (state_q == OFF_WT2) && SPI_done;
  assign flopGain   = (state_q == GAIN_WT2) && SPI_done;
  assign ren        = (state_q == RD);
  assign dump_done  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign ss         = 3'b100;
  assign wrt_SPI    = wrt_q;
  assign SPI_data   = spi_data_q;
  assign ram_addr   = addr_q;
  assign ch_sel     = ch_q;
  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;

endmodule
